// File: rtl/armleocpu_defines.sv
// Shared RV32I decode constants: opcodes, instruction field bit ranges and the
// decode output register state type.
package armleocpu_defines;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;
    localparam int IMM12_LSB  = 20;
    localparam int IMM12_MSB  = 31;

    typedef enum logic {
        D2E_EMPTY = 1'b0,
        D2E_FULL  = 1'b1
    } d2eState_t;

    function automatic logic [31:0] signExtend12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/armleocpu_decode_if.sv
// Fetch->decode, register-file, writeback and decode->execute signals of the decode stage.
// wb_data only exists when ARMLEOCPU_DECODE_BYPASS_EN is defined.
interface armleocpu_decode_if;

    logic        f2d_valid;
    logic        f2d_ready;
    logic [31:0] f2d_instr;
    logic [31:0] f2d_pc;

    logic [4:0]  rf_rs1_addr;
    logic [4:0]  rf_rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;

    logic        wb_valid;
    logic [4:0]  wb_rd;
`ifdef ARMLEOCPU_DECODE_BYPASS_EN
    logic [31:0] wb_data;
`endif

    logic        flush;

    logic        d2e_valid;
    logic        d2e_ready;
    logic [31:0] d2e_pc;
    logic        d2e_is_op;
    logic        d2e_is_op_imm;
    logic [2:0]  d2e_funct3;
    logic [6:0]  d2e_funct7;
    logic [4:0]  d2e_shamt;
    logic [31:0] d2e_rs1;
    logic [31:0] d2e_rs2;
    logic [31:0] d2e_simm12;
    logic [4:0]  d2e_rd;
    logic        d2e_illegal;

    // Decode side
    modport slave (
`ifdef ARMLEOCPU_DECODE_BYPASS_EN
        input  wb_data,
`endif
        input  f2d_valid, f2d_instr, f2d_pc,
        input  rf_rs1_data, rf_rs2_data,
        input  wb_valid, wb_rd, flush, d2e_ready,
        output f2d_ready, rf_rs1_addr, rf_rs2_addr,
        output d2e_valid, d2e_pc, d2e_is_op, d2e_is_op_imm, d2e_funct3, d2e_funct7,
        output d2e_shamt, d2e_rs1, d2e_rs2, d2e_simm12, d2e_rd, d2e_illegal
    );

    // Surrounding pipeline side
    modport master (
`ifdef ARMLEOCPU_DECODE_BYPASS_EN
        output wb_data,
`endif
        output f2d_valid, f2d_instr, f2d_pc,
        output rf_rs1_data, rf_rs2_data,
        output wb_valid, wb_rd, flush, d2e_ready,
        input  f2d_ready, rf_rs1_addr, rf_rs2_addr,
        input  d2e_valid, d2e_pc, d2e_is_op, d2e_is_op_imm, d2e_funct3, d2e_funct7,
        input  d2e_shamt, d2e_rs1, d2e_rs2, d2e_simm12, d2e_rd, d2e_illegal
    );

endinterface

// File: rtl/armleocpu_scoreboard.sv
// 32-entry register busy scoreboard: set on issue, clear on writeback, flush clears all.
// A set and a clear of the same index in one cycle leave the bit set; x0 is never busy.
module armleocpu_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       set_valid_i,
    input  logic [4:0] set_idx_i,
    input  logic       clr_valid_i,
    input  logic [4:0] clr_idx_i,
    input  logic [4:0] lookup_a_i,
    input  logic [4:0] lookup_b_i,
    output logic       busy_a_o,
    output logic       busy_b_o
);

    logic [31:0] busy_q;
    logic [31:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_valid_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        if (set_valid_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Flush takes priority so a writeback in the flush cycle has no effect
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_a_o = busy_q[lookup_a_i];
    assign busy_b_o = busy_q[lookup_b_i];

endmodule

// File: rtl/armleocpu_decode.sv
// RV32I single-entry decode/issue stage with RAW scoreboard in front of the ALU.
// Optional writeback bypass enabled by defining ARMLEOCPU_DECODE_BYPASS_EN.
module armleocpu_decode
    import armleocpu_defines::*;
(
    input logic              clk,
    input logic              rst,
    armleocpu_decode_if.slave decodeBus
);

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rs1Idx;
    logic [4:0]  rs2Idx;
    logic [4:0]  rdIdx;
    logic        isOp;
    logic        isOpImm;
    logic        isLegal;
    logic        rs1Used;
    logic        rs2Used;
    logic        busyRs1;
    logic        busyRs2;
    logic        fwdRs1;
    logic        fwdRs2;
    logic [31:0] rs1Value;
    logic [31:0] rs2Value;
    logic        hazard;
    logic        canLoad;
    logic        accept;
    d2eState_t   state_q;

    assign instr   = decodeBus.f2d_instr;
    assign opcode  = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs1Idx  = instr[RS1_MSB:RS1_LSB];
    assign rs2Idx  = instr[RS2_MSB:RS2_LSB];
    assign rdIdx   = instr[RD_MSB:RD_LSB];
    assign isOp    = (opcode == OPCODE_OP);
    assign isOpImm = (opcode == OPCODE_OP_IMM);
    assign isLegal = isOp || isOpImm;

    assign rs1Used = isLegal && (rs1Idx != 5'd0);
    assign rs2Used = isOp && (rs2Idx != 5'd0);

    assign decodeBus.rf_rs1_addr = rs1Idx;
    assign decodeBus.rf_rs2_addr = rs2Idx;

`ifdef ARMLEOCPU_DECODE_BYPASS_EN
    // Only a pending result being retired right now may be forwarded
    assign fwdRs1   = rs1Used && busyRs1 && decodeBus.wb_valid && (decodeBus.wb_rd == rs1Idx);
    assign fwdRs2   = rs2Used && busyRs2 && decodeBus.wb_valid && (decodeBus.wb_rd == rs2Idx);
    assign rs1Value = fwdRs1 ? decodeBus.wb_data : decodeBus.rf_rs1_data;
    assign rs2Value = fwdRs2 ? decodeBus.wb_data : decodeBus.rf_rs2_data;
`else
    assign fwdRs1   = 1'b0;
    assign fwdRs2   = 1'b0;
    assign rs1Value = decodeBus.rf_rs1_data;
    assign rs2Value = decodeBus.rf_rs2_data;
`endif

    assign hazard  = decodeBus.f2d_valid &&
                     ((rs1Used && busyRs1 && !fwdRs1) || (rs2Used && busyRs2 && !fwdRs2));
    assign canLoad = (state_q == D2E_EMPTY) || decodeBus.d2e_ready;

    assign decodeBus.f2d_ready = canLoad && !hazard && !decodeBus.flush;
    assign accept              = decodeBus.f2d_valid && decodeBus.f2d_ready;
    assign decodeBus.d2e_valid = (state_q == D2E_FULL);

    armleocpu_scoreboard scoreboard (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (decodeBus.flush),
        .set_valid_i (accept && isLegal && (rdIdx != 5'd0)),
        .set_idx_i   (rdIdx),
        .clr_valid_i (decodeBus.wb_valid && (decodeBus.wb_rd != 5'd0)),
        .clr_idx_i   (decodeBus.wb_rd),
        .lookup_a_i  (rs1Idx),
        .lookup_b_i  (rs2Idx),
        .busy_a_o    (busyRs1),
        .busy_b_o    (busyRs2)
    );

    // Output register: payload only changes on accept, so it is stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                 <= D2E_EMPTY;
            decodeBus.d2e_pc        <= '0;
            decodeBus.d2e_is_op     <= 1'b0;
            decodeBus.d2e_is_op_imm <= 1'b0;
            decodeBus.d2e_funct3    <= '0;
            decodeBus.d2e_funct7    <= '0;
            decodeBus.d2e_shamt     <= '0;
            decodeBus.d2e_rs1       <= '0;
            decodeBus.d2e_rs2       <= '0;
            decodeBus.d2e_simm12    <= '0;
            decodeBus.d2e_rd        <= '0;
            decodeBus.d2e_illegal   <= 1'b0;
        end else if (decodeBus.flush) begin
            state_q <= D2E_EMPTY;
        end else if (accept) begin
            state_q                 <= D2E_FULL;
            decodeBus.d2e_pc        <= decodeBus.f2d_pc;
            decodeBus.d2e_is_op     <= isOp;
            decodeBus.d2e_is_op_imm <= isOpImm;
            decodeBus.d2e_funct3    <= instr[FUNCT3_MSB:FUNCT3_LSB];
            decodeBus.d2e_funct7    <= instr[FUNCT7_MSB:FUNCT7_LSB];
            decodeBus.d2e_shamt     <= instr[RS2_MSB:RS2_LSB];
            decodeBus.d2e_rs1       <= rs1Value;
            decodeBus.d2e_rs2       <= rs2Value;
            decodeBus.d2e_simm12    <= signExtend12(instr[IMM12_MSB:IMM12_LSB]);
            decodeBus.d2e_rd        <= rdIdx;
            decodeBus.d2e_illegal   <= !isLegal;
        end else if (decodeBus.d2e_ready) begin
            state_q <= D2E_EMPTY;
        end
    end

endmodule

// File: tb/tb_armleocpu_decode.sv
// Bench for armleocpu_decode: directed scenarios then random traffic against a
// behavioural scoreboard/pipeline model. Honours ARMLEOCPU_DECODE_BYPASS_EN.
module tb_armleocpu_decode;

`ifdef ARMLEOCPU_DECODE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    armleocpu_decode_if ifc ();

    armleocpu_decode dut (
        .clk       (clk),
        .rst       (rst),
        .decodeBus (ifc.slave)
    );

    int total = 0;
    int bad   = 0;

    bit          busyM [32];
    bit          expValid;
    logic [31:0] expPc, expRs1, expRs2, expSimm;
    logic [6:0]  expF7;
    logic [4:0]  expShamt, expRd;
    logic [2:0]  expF3;
    bit          expIsOp, expIsOpImm, expIllegal;
    bit          lastReady;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit srcBlocked(input logic [4:0] idx, input bit wbv, input logic [4:0] wbrd);
        if (idx == 5'd0 || !busyM[idx]) return 1'b0;
        if (BYPASS && wbv && wbrd == idx) return 1'b0;
        return 1'b1;
    endfunction

    task automatic verifyOutputs();
        checkOutput("d2e_valid", {31'd0, ifc.d2e_valid}, {31'd0, expValid});
        if (expValid) begin
            checkOutput("d2e_pc", ifc.d2e_pc, expPc);
            checkOutput("d2e_is_op", {31'd0, ifc.d2e_is_op}, {31'd0, expIsOp});
            checkOutput("d2e_is_op_imm", {31'd0, ifc.d2e_is_op_imm}, {31'd0, expIsOpImm});
            checkOutput("d2e_illegal", {31'd0, ifc.d2e_illegal}, {31'd0, expIllegal});
            checkOutput("d2e_funct3", {29'd0, ifc.d2e_funct3}, {29'd0, expF3});
            checkOutput("d2e_funct7", {25'd0, ifc.d2e_funct7}, {25'd0, expF7});
            checkOutput("d2e_shamt", {27'd0, ifc.d2e_shamt}, {27'd0, expShamt});
            checkOutput("d2e_rd", {27'd0, ifc.d2e_rd}, {27'd0, expRd});
            checkOutput("d2e_simm12", ifc.d2e_simm12, expSimm);
            if (expIsOp || expIsOpImm) checkOutput("d2e_rs1", ifc.d2e_rs1, expRs1);
            if (expIsOp) checkOutput("d2e_rs2", ifc.d2e_rs2, expRs2);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance model, check registers
    task automatic applyStimulus(input bit valid, input logic [31:0] instr, input logic [31:0] pc,
                                 input bit wbv, input logic [4:0] wbrd, input logic [31:0] wbd,
                                 input bit fl, input bit dr);
        logic [6:0]  opc;
        logic [4:0]  a1, a2, rd;
        logic [31:0] d1, d2, e1, e2;
        logic [11:0] imm;
        bit useRs1, useRs2, blocked, accept;
        opc = instr[6:0];
        a1  = instr[19:15];
        a2  = instr[24:20];
        rd  = instr[11:7];
        imm = instr[31:20];
        d1  = (a1 == 5'd0) ? 32'd0 : $urandom;
        d2  = (a2 == 5'd0) ? 32'd0 : $urandom;
        ifc.f2d_valid   = valid;
        ifc.f2d_instr   = instr;
        ifc.f2d_pc      = pc;
        ifc.rf_rs1_data = d1;
        ifc.rf_rs2_data = d2;
        ifc.wb_valid    = wbv;
        ifc.wb_rd       = wbrd;
`ifdef ARMLEOCPU_DECODE_BYPASS_EN
        ifc.wb_data     = wbd;
`endif
        ifc.flush       = fl;
        ifc.d2e_ready   = dr;
        #1;
        useRs1  = (opc == 7'h33) || (opc == 7'h13);
        useRs2  = (opc == 7'h33);
        blocked = (useRs1 && srcBlocked(a1, wbv, wbrd)) || (useRs2 && srcBlocked(a2, wbv, wbrd));
        lastReady = (!expValid || dr) && !fl && !blocked;
        checkOutput("rf_rs1_addr", {27'd0, ifc.rf_rs1_addr}, {27'd0, a1});
        checkOutput("rf_rs2_addr", {27'd0, ifc.rf_rs2_addr}, {27'd0, a2});
        if (valid) checkOutput("f2d_ready", {31'd0, ifc.f2d_ready}, {31'd0, lastReady});
        accept = valid && lastReady;
        e1 = (BYPASS && a1 != 5'd0 && busyM[a1] && wbv && wbrd == a1) ? wbd : d1;
        e2 = (BYPASS && a2 != 5'd0 && busyM[a2] && wbv && wbrd == a2) ? wbd : d2;
        if (fl) begin
            expValid = 1'b0;
            busyM    = '{default: 1'b0};
        end else begin
            if (wbv && wbrd != 5'd0) busyM[wbrd] = 1'b0;
            if (accept) begin
                if (useRs1 && rd != 5'd0) busyM[rd] = 1'b1;
                expValid   = 1'b1;
                expPc      = pc;
                expIsOp    = (opc == 7'h33);
                expIsOpImm = (opc == 7'h13);
                expIllegal = !useRs1;
                expF3      = instr[14:12];
                expF7      = instr[31:25];
                expShamt   = a2;
                expRd      = rd;
                expSimm    = 32'($signed(imm));
                expRs1     = e1;
                expRs2     = e2;
            end else if (dr) begin
                expValid = 1'b0;
            end
        end
        @(negedge clk);
        verifyOutputs();
    endtask

    task automatic doReset();
        rst = 1'b1;
        ifc.f2d_valid = 1'b0; ifc.f2d_instr = '0; ifc.f2d_pc = '0;
        ifc.rf_rs1_data = '0; ifc.rf_rs2_data = '0;
        ifc.wb_valid = 1'b0; ifc.wb_rd = '0; ifc.flush = 1'b0; ifc.d2e_ready = 1'b0;
`ifdef ARMLEOCPU_DECODE_BYPASS_EN
        ifc.wb_data = '0;
`endif
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, ifc.d2e_valid}, 32'd0);
        checkOutput("rst_pc", ifc.d2e_pc, 32'd0);
        checkOutput("rst_rs1", ifc.d2e_rs1, 32'd0);
        checkOutput("rst_rs2", ifc.d2e_rs2, 32'd0);
        checkOutput("rst_simm12", ifc.d2e_simm12, 32'd0);
        checkOutput("rst_fields", {ifc.d2e_is_op, ifc.d2e_is_op_imm, ifc.d2e_illegal, ifc.d2e_funct3,
                                   ifc.d2e_funct7, ifc.d2e_shamt, ifc.d2e_rd}, 32'd0);
        checkOutput("rst_f2d_ready", {31'd0, ifc.f2d_ready}, 32'd1);
        rst = 1'b0;
        busyM = '{default: 1'b0};
        expValid = 1'b0;
        expPc = '0; expRs1 = '0; expRs2 = '0; expSimm = '0; expF7 = '0; expShamt = '0;
        expRd = '0; expF3 = '0; expIsOp = 1'b0; expIsOpImm = 1'b0; expIllegal = 1'b0;
    endtask

    initial begin
        logic [31:0] instr;
        logic [6:0]  opc;
        int          sel;

        doReset();

        // addi x1,x0,5 at 0x100
        applyStimulus(1, 32'h00500093, 32'h100, 0, 0, 0, 0, 1);
        checkOutput("addi_valid", {31'd0, ifc.d2e_valid}, 32'd1);
        checkOutput("addi_is_op_imm", {31'd0, ifc.d2e_is_op_imm}, 32'd1);
        checkOutput("addi_simm12", ifc.d2e_simm12, 32'd5);
        checkOutput("addi_rd", {27'd0, ifc.d2e_rd}, 32'd1);
        checkOutput("addi_pc", ifc.d2e_pc, 32'h100);

        // add x3,x1,x2 waits for x1 writeback
        applyStimulus(1, 32'h002081B3, 32'h104, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h002081B3, 32'h104, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h002081B3, 32'h104, 1, 1, 32'h55, 0, 1);
`ifdef ARMLEOCPU_DECODE_BYPASS_EN
        checkOutput("byp_valid", {31'd0, ifc.d2e_valid}, 32'd1);
        checkOutput("byp_rs1", ifc.d2e_rs1, 32'h55);
`else
        checkOutput("nobyp_stall_valid", {31'd0, ifc.d2e_valid}, 32'd0);
        applyStimulus(1, 32'h002081B3, 32'h104, 0, 0, 0, 0, 1);
        checkOutput("nobyp_issue_rd", {27'd0, ifc.d2e_rd}, 32'd3);
`endif

        // Backpressure: hold x6 result for 3 cycles, then stream
        applyStimulus(1, 32'h00100313, 32'h200, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h00200393, 32'h204, 0, 0, 0, 0, 0);
            checkOutput("bp_hold_pc", ifc.d2e_pc, 32'h200);
            checkOutput("bp_hold_rd", {27'd0, ifc.d2e_rd}, 32'd6);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h00200393, 32'h204 + 32'(4 * i), 0, 0, 0, 0, 1);
            checkOutput("bp_stream_pc", ifc.d2e_pc, 32'h204 + 32'(4 * i));
        end

        // Set wins over same-cycle clear on x5
        applyStimulus(1, 32'h00900293, 32'h300, 1, 5, 32'h77, 0, 1);
        applyStimulus(1, 32'h00028433, 32'h304, 0, 0, 0, 0, 1);
        checkOutput("setwins_stall", {31'd0, ifc.d2e_valid}, 32'd0);
        applyStimulus(0, 32'h0, 32'h0, 1, 5, 32'h0, 0, 1);

        // Load opcode is illegal and sets no busy bit
        applyStimulus(1, 32'h00002483, 32'h400, 0, 0, 0, 0, 1);
        checkOutput("ld_illegal", {31'd0, ifc.d2e_illegal}, 32'd1);
        checkOutput("ld_ops", {30'd0, ifc.d2e_is_op, ifc.d2e_is_op_imm}, 32'd0);
        applyStimulus(1, 32'h00148513, 32'h404, 0, 0, 0, 0, 1);
        checkOutput("ld_nohazard_pc", ifc.d2e_pc, 32'h404);

        // Flush while full with x7 busy
        applyStimulus(1, 32'h00100393, 32'h500, 0, 0, 0, 0, 1);
        applyStimulus(1, 32'h007385B3, 32'h504, 0, 0, 0, 1, 0);
        checkOutput("flush_valid", {31'd0, ifc.d2e_valid}, 32'd0);
        applyStimulus(1, 32'h007385B3, 32'h504, 0, 0, 0, 0, 1);
        checkOutput("flush_busy_clear_rd", {27'd0, ifc.d2e_rd}, 32'd11);

        // srai x2,x1,3
        applyStimulus(1, 32'h4030D113, 32'h600, 0, 0, 0, 0, 1);
        checkOutput("srai_shamt", {27'd0, ifc.d2e_shamt}, 32'd3);
        checkOutput("srai_funct7", {25'd0, ifc.d2e_funct7}, 32'h20);
        checkOutput("srai_simm12", ifc.d2e_simm12, 32'h00000403);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                sel = $urandom_range(0, 9);
                if (sel < 4)      opc = 7'h33;
                else if (sel < 8) opc = 7'h13;
                else if (sel < 9) opc = 7'h03;
                else              opc = 7'($urandom);
                instr = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         3'($urandom), 5'($urandom_range(0, 7)), opc};
                applyStimulus($urandom_range(0, 9) < 8, instr, $urandom,
                              $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom,
                              $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
